// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
//   Program counter for the 8-bit CPU family. It supports absolute jumps,
//   signed relative branches, increment, and a hardware call/return stack.
//   Sticky error flags record PC wrap, stack overflow and stack underflow.
//
// Ports
//   clk              system clock; all state changes on the rising edge
//   reset            asynchronous, active-low reset
//   jump             PC <= address_input                 (highest priority)
//   call             push PC+1, then PC <= address_input
//   ret              PC <= top of stack, pop
//   branch           PC <= PC + sign-extended offset
//   increment        PC <= PC + 1                        (lowest priority)
//   clear_flags      clear sticky flags (a same-cycle set event wins)
//   address_input    jump/call target
//   offset           two's-complement branch displacement
//   current_address  registered PC
//   stack_count      number of valid return addresses
//   pc_overflow      sticky: the PC wrapped past either end of the address space
//   stack_overflow   sticky: a call was made with the stack full
//   stack_underflow  sticky: a ret was made with the stack empty
// -----------------------------------------------------------------------------
module pc_stack_unit #(
  parameter int ADDR_WIDTH   = 4,
  parameter int STACK_DEPTH  = 4,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               branch,
  input  logic                               increment,
  input  logic                               clear_flags,
  input  logic [ADDR_WIDTH-1:0]              address_input,
  input  logic [OFFSET_WIDTH-1:0]            offset,
  output logic [ADDR_WIDTH-1:0]              current_address,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               pc_overflow,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pco_q, pco_d;
  logic                  so_q, so_d;
  logic                  su_q, su_d;

  // Return-address storage. Its contents are don't-care after reset, so it
  // has no reset and can map onto distributed RAM.
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic                  push_en;
  logic [IW-1:0]         push_idx;
  logic [IW-1:0]         top_idx;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH:0]   branch_sum;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  set_pco, set_so, set_su;

  assign pc_plus1    = pc_q + ADDR_WIDTH'(1);
  assign stack_full  = (cnt_q == CW'(STACK_DEPTH));
  assign stack_empty = (cnt_q == '0);
  assign push_idx    = IW'(cnt_q);
  assign top_idx     = IW'(cnt_q - CW'(1));

  // The PC is zero-extended and the offset is sign-extended, one bit wider
  // than the address. The top bit of the sum is set both on a carry past
  // all-ones (positive offset) and on a result below zero (negative offset).
  // Because |offset| <= 2^(ADDR_WIDTH-1), these two cases cannot alias.
  assign branch_sum = {1'b0, pc_q}
                    + {{(ADDR_WIDTH + 1 - OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    push_en = 1'b0;
    set_pco = 1'b0;
    set_so  = 1'b0;
    set_su  = 1'b0;

    if (jump) begin
      pc_d = address_input;
    end else if (call) begin
      if (stack_full) begin
        set_so = 1'b1;
      end else begin
        push_en = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        pc_d    = address_input;
      end
    end else if (ret) begin
      if (stack_empty) begin
        set_su = 1'b1;
      end else begin
        pc_d  = stack_mem[top_idx];
        cnt_d = cnt_q - CW'(1);
      end
    end else if (branch) begin
      pc_d    = branch_sum[ADDR_WIDTH-1:0];
      set_pco = branch_sum[ADDR_WIDTH];
    end else if (increment) begin
      pc_d    = pc_plus1;
      set_pco = &pc_q;
    end

    // A set event in the same cycle takes precedence over clear_flags.
    pco_d = set_pco | (pco_q & ~clear_flags);
    so_d  = set_so  | (so_q  & ~clear_flags);
    su_d  = set_su  | (su_q  & ~clear_flags);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
      pco_q <= 1'b0;
      so_q  <= 1'b0;
      su_q  <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      pco_q <= pco_d;
      so_q  <= so_d;
      su_q  <= su_d;
    end
  end

  // The return address wraps silently and never raises pc_overflow.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_plus1;
    end
  end

  assign current_address = pc_q;
  assign stack_count     = cnt_q;
  assign pc_overflow     = pco_q;
  assign stack_overflow  = so_q;
  assign stack_underflow = su_q;

endmodule
